main_mem_responder: RTL and testbench

- Word-addressed main-memory model; serves the memory side of the cache miss-fill interface.
- Accepts at most one request per cycle: a read or a write.
- Reads are fully pipelined. Each read returns its data with a one-cycle valid pulse exactly LATENCY cycles after it is issued.
- Shared by the I-cache and D-cache fill paths through the top-level memory arbiter.

---
 rtl/mem_defs.sv | 15 +
 rtl/mem_pipe_stage.sv | 29 ++
 rtl/main_mem_responder.sv | 85 ++++++++
 tb/tb_main_mem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared constants for the main-memory responder and the cache fill path.
// The fill FSM imports the same latency and widths, so its request count and
// its wait time stay matched to the memory model.
package mem_defs;

    localparam int MEM_LATENCY = 4;
    localparam int MEM_ADDR_W  = 16;
    localparam int WORD_W      = 16;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_e;

endpackage

// File: rtl/mem_pipe_stage.sv
// One stage of the read-return pipeline: a valid bit and a data word.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   valid_in   - valid bit from the previous stage
//   data_in    - data word from the previous stage
//   valid_out  - registered valid bit
//   data_out   - registered data word
module mem_pipe_stage
    import mem_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              valid_out,
    output logic [WORD_W-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in;
            data_out  <= data_in;
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Word-addressed main-memory model serving the cache miss-fill interface.
// One request per cycle (read or write); reads return through a fixed
// LATENCY-deep pipeline with no stall and no backpressure.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset (array contents kept)
//   enable      - request strobe
//   wr          - request type: 1 = write, 0 = read
//   addr        - word address, low ADDR_W bits used
//   data_in     - write data
//   data_out    - read data, zero whenever data_valid is low
//   data_valid  - one-cycle pulse marking returned read data
//   rd_pending  - reads issued but not yet returned (0..LATENCY)
module main_mem_responder
    import mem_defs::*;
#(
    parameter int    ADDR_W    = MEM_ADDR_W,
    parameter int    LATENCY   = MEM_LATENCY,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        rd_pending
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];

    logic [ADDR_W-1:0] word_addr;
    req_e              req_type;
    logic              rd_accept;
    logic              wr_accept;

    assign word_addr = addr[ADDR_W-1:0];
    assign req_type  = req_e'(wr);
    assign rd_accept = enable && !rst && (req_type == REQ_RD);
    assign wr_accept = enable && !rst && (req_type == REQ_WR);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_addr] <= data_in;
        end
    end

    // Stage 0 input is the combinational array read, so a read captures the
    // word before any later write lands. Idle slots carry zero data, which
    // keeps data_out at zero whenever data_valid is low without extra muxing.
    logic [LATENCY:0]  stage_valid;
    logic [WORD_W-1:0] stage_data [0:LATENCY];

    assign stage_valid[0] = rd_accept;
    assign stage_data[0]  = rd_accept ? mem[word_addr] : '0;

    for (genvar i = 0; i < LATENCY; i++) begin : g_pipe
        mem_pipe_stage u_stage (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (stage_valid[i]),
            .data_in   (stage_data[i]),
            .valid_out (stage_valid[i+1]),
            .data_out  (stage_data[i+1])
        );
    end

    assign data_valid = stage_valid[LATENCY];
    assign data_out   = stage_data[LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= '0;
        end else begin
            case ({rd_accept, data_valid})
                2'b10:   rd_pending <= rd_pending + 4'd1;
                2'b01:   rd_pending <= rd_pending - 4'd1;
                default: rd_pending <= rd_pending;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized and directed bench for main_mem_responder against a queue-based
// reference: each accepted read is scheduled with its due cycle and the word
// it must return.
module tb_main_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, enable, wr;
    logic [15:0] addr, data_in, data_out;
    logic        data_valid;
    logic [3:0]  rd_pending;

    logic        u8_rst, u8_enable, u8_wr;
    logic [15:0] u8_addr, u8_data_in, u8_data_out;
    logic        u8_data_valid;
    logic [3:0]  u8_rd_pending;

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .rd_pending(rd_pending)
    );

    main_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut8 (
        .clk(clk), .rst(u8_rst), .enable(u8_enable), .wr(u8_wr), .addr(u8_addr),
        .data_in(u8_data_in), .data_out(u8_data_out), .data_valid(u8_data_valid),
        .rd_pending(u8_rd_pending)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    resp_t       sched[$];
    logic [15:0] got_q[$];
    logic [15:0] mdl [int];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    int          reads = 0;
    int          max_pend = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one cycle of inputs, advance past the edge, update the reference
    // and compare every output.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        logic        exp_v;
        logic [15:0] exp_d;
        int          exp_p;
        rst = r; enable = e; wr = w; addr = a; data_in = d;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            sched.delete();
        end else if (e && w) begin
            mdl[int'(a)] = d;
        end else if (e) begin
            sched.push_back('{cyc + LAT - 1, mdl[int'(a)]});
            reads++;
        end
        exp_v = (sched.size() > 0) && (sched[0].due == cyc);
        exp_d = exp_v ? sched[0].data : 16'h0000;
        exp_p = sched.size();
        check_eq("data_valid", {31'b0, data_valid}, {31'b0, exp_v});
        check_eq("data_out", {16'b0, data_out}, {16'b0, exp_d});
        check_eq("rd_pending", {28'b0, rd_pending}, exp_p);
        if (exp_v) void'(sched.pop_front());
        if (data_valid) begin
            pulses++;
            got_q.push_back(data_out);
        end
        if (int'(rd_pending) > max_pend) max_pend = int'(rd_pending);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        u8_rst = 1'b1; u8_enable = 1'b0; u8_wr = 1'b0; u8_addr = '0; u8_data_in = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("reset_valid", {31'b0, data_valid}, 32'd0);
        check_eq("reset_pending", {28'b0, rd_pending}, 32'd0);

        // Single write then read
        got_q.delete(); pulses = 0;
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        idle(LAT - 2);
        check_eq("t1_not_early", {31'b0, data_valid}, 32'd0);
        idle(1);
        check_eq("t1_valid", {31'b0, data_valid}, 32'd1);
        check_eq("t1_data", {16'b0, data_out}, 32'hBEEF);
        idle(3);
        check_eq("t1_one_pulse", pulses, 32'd1);

        // Burst of eight reads
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        got_q.delete(); pulses = 0; max_pend = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0);
        idle(LAT);
        check_eq("t2_pulses", pulses, 32'd8);
        for (int i = 0; i < 8; i++)
            check_eq("t2_order", (i < got_q.size()) ? {16'b0, got_q[i]} : 32'hFFFF_FFFF,
                     32'hA000 + 32'(i));
        check_eq("t2_max_pending", max_pend, LAT);
        check_eq("t2_final_pending", {28'b0, rd_pending}, 32'd0);

        // Read-before-write and write-before-read ordering
        step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
        got_q.delete();
        step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        idle(LAT);
        check_eq("t3_count", got_q.size(), 32'd2);
        check_eq("t3_old", (got_q.size() > 0) ? {16'b0, got_q[0]} : 32'hFFFF_FFFF, 32'h1111);
        check_eq("t3_new", (got_q.size() > 1) ? {16'b0, got_q[1]} : 32'hFFFF_FFFF, 32'h2222);

        // Reset discards in-flight reads; read under reset is ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0);
        pulses = 0;
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
        check_eq("t4_pending_clr", {28'b0, rd_pending}, 32'd0);
        idle(LAT + 1);
        check_eq("t4_no_pulse", pulses, 32'd0);
        check_eq("t4_pending", {28'b0, rd_pending}, 32'd0);

        // Address aliasing on an 8-bit instance
        @(posedge clk); #1;
        u8_rst = 1'b0; u8_enable = 1'b1; u8_wr = 1'b1; u8_addr = 16'h0003; u8_data_in = 16'h5A5A;
        @(posedge clk); #1;
        u8_wr = 1'b0; u8_addr = 16'hFF03; u8_data_in = 16'h0;
        @(posedge clk); #1;
        u8_enable = 1'b0;
        check_eq("t5_pending", {28'b0, u8_rd_pending}, 32'd1);
        for (int i = 0; i < LAT - 2; i++) begin
            @(posedge clk); #1;
            check_eq("t5_not_early", {31'b0, u8_data_valid}, 32'd0);
            check_eq("t5_zero_data", {16'b0, u8_data_out}, 32'd0);
        end
        @(posedge clk); #1;
        check_eq("t5_valid", {31'b0, u8_data_valid}, 32'd1);
        check_eq("t5_data", {16'b0, u8_data_out}, 32'h5A5A);

        // Random interleaved traffic on a small preloaded window
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 16'h0200 + 16'(i), 16'($urandom));
        pulses = 0; reads = 0;
        for (int i = 0; i < 200; i++) begin
            logic        e, w;
            logic [15:0] a, d;
            e = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 16'h0200 + 16'($urandom_range(0, 15));
            d = 16'($urandom);
            step(1'b0, e, w, a, d);
        end
        idle(LAT);
        check_eq("t6_pulse_count", pulses, reads);
        check_eq("t6_drained", {28'b0, rd_pending}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
